sequence_calculator_param: RTL

//   Parametrised successor to the fixed 16-bit Fibonacci engine. Computes the n-th term of a
//   two-term additive recurrence a(k+2)=a(k)+a(k+1), one term per clock. Three seed modes:

---
 rtl/sequence_calculator_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sequence_calculator_param.sv
// rtl/sequence_calculator_param.sv - n-th term of a two-term additive recurrence, one term per clock
// Seeds: Fibonacci, Lucas or custom. Overflow of a term either wraps or saturates.
module sequence_calculator_param #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  n_i,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed0_i,
  input  logic [DATA_W-1:0] seed1_i,
  input  logic              sat_en,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              a_ovf_q, a_ovf_d, b_ovf_q, b_ovf_d;
  logic              sat_q, sat_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W:0]   sum;
  logic              carry;
  logic [DATA_W-1:0] seed0_sel, seed1_sel;

  assign sum   = {1'b0, a_q} + {1'b0, b_q};
  assign carry = sum[DATA_W];

  always_comb begin
    seed0_sel = '0;
    seed1_sel = DATA_W'(1);
    case (mode)
      2'b01: begin
        seed0_sel = DATA_W'(2);
        seed1_sel = DATA_W'(1);
      end
      2'b10: begin
        seed0_sel = seed0_i;
        seed1_sel = seed1_i;
      end
      default: begin
        seed0_sel = '0;
        seed1_sel = DATA_W'(1);
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    a_ovf_d  = a_ovf_q;
    b_ovf_d  = b_ovf_q;
    sat_d    = sat_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = seed0_sel;
          b_d     = seed1_sel;
          cnt_d   = n_i;
          a_ovf_d = 1'b0;
          b_ovf_d = 1'b0;
          sat_d   = sat_en;
          state_d = S_CALC;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_CALC: begin
        if (cnt_q != '0) begin
          a_d     = b_q;
          b_d     = (sat_q && carry) ? '1 : sum[DATA_W-1:0];
          // Tags travel with their terms so only a(n) itself reports overflow.
          a_ovf_d = b_ovf_q;
          b_ovf_d = carry | a_ovf_q | b_ovf_q;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          result_d = a_q;
          ovf_d    = a_ovf_q;
          state_d  = S_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      a_ovf_q  <= 1'b0;
      b_ovf_q  <= 1'b0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      a_ovf_q  <= a_ovf_d;
      b_ovf_q  <= b_ovf_d;
      sat_q    <= sat_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;

endmodule
